// File: rtl/rob_mc_pkg.sv
// Shared definitions for the multi-commit reorder buffer: entry kinds and
// default sizing used by the top level and the commit selector.
package rob_mc_pkg;

  localparam int ROB_DEF_DEPTH = 16;
  localparam int ROB_DEF_REG_W = 5;
  localparam int ROB_DEF_XLEN  = 32;
  localparam int ROB_DEF_WB_CH = 3;
  localparam int ROB_DEF_CMT_W = 2;

  typedef enum logic [1:0] {
    ROB_ALU    = 2'd0,
    ROB_LOAD   = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_BRANCH = 2'd3
  } rob_type_e;

  // True when an entry kind writes memory at retirement.
  function automatic logic rob_is_store(input logic [1:0] kind);
    return (kind == ROB_STORE);
  endfunction

  // True when an entry kind can redirect the front end at retirement.
  function automatic logic rob_is_branch(input logic [1:0] kind);
    return (kind == ROB_BRANCH);
  endfunction

endpackage

// File: rtl/rob_mc_commit_sel.sv
// Combinational retirement window scan. Walks the CMT_W oldest entries in
// order and decides which of them retire this cycle, how far the head moves,
// and whether a mispredicted branch closes the group.
module rob_mc_commit_sel
  import rob_mc_pkg::*;
#(
  parameter int CMT_W = ROB_DEF_CMT_W,
  parameter int CNT_W = $clog2(CMT_W + 1)
) (
  input  logic [CMT_W-1:0]   win_live,
  input  logic [CMT_W-1:0]   win_ready,
  input  logic [CMT_W-1:0]   win_mispred,
  input  logic [2*CMT_W-1:0] win_type,
  output logic [CMT_W-1:0]   cmt_mask,
  output logic [CNT_W-1:0]   adv_cnt,
  output logic [CMT_W-1:0]   flush_slot,
  output logic               flush_hit
);

  logic scan_go;
  logic store_seen;
  logic slot_store;
  logic slot_branch;

  // In-order scan: a slot retires only if every older slot retired, at most one store per group, and a mispredicted branch ends the group.
  always_comb begin
    cmt_mask    = '0;
    adv_cnt     = '0;
    flush_slot  = '0;
    flush_hit   = 1'b0;
    scan_go     = 1'b1;
    store_seen  = 1'b0;
    slot_store  = 1'b0;
    slot_branch = 1'b0;
    for (int k = 0; k < CMT_W; k++) begin
      slot_store  = rob_is_store(win_type[2*k +: 2]);
      slot_branch = rob_is_branch(win_type[2*k +: 2]);
      if (scan_go && win_live[k] && win_ready[k] && !(slot_store && store_seen)) begin
        cmt_mask[k] = 1'b1;
        adv_cnt     = adv_cnt + CNT_W'(1);
        if (slot_store) begin
          store_seen = 1'b1;
        end else begin
          store_seen = store_seen;
        end
        if (slot_branch && win_mispred[k]) begin
          flush_slot[k] = 1'b1;
          flush_hit     = 1'b1;
          scan_go       = 1'b0;
        end else begin
          scan_go = scan_go;
        end
      end else begin
        scan_go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer. One allocation per cycle at the tail, WB_CH
// result channels, up to CMT_W in-order retirements per cycle from the head,
// mispredict redirect from the head, external flush and an operand
// forwarding lookup. Pointers carry a wrap bit so full and empty differ.
module rob_mc
  import rob_mc_pkg::*;
#(
  parameter int DEPTH = ROB_DEF_DEPTH,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int REG_W = ROB_DEF_REG_W,
  parameter int XLEN  = ROB_DEF_XLEN,
  parameter int WB_CH = ROB_DEF_WB_CH,
  parameter int CMT_W = ROB_DEF_CMT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   ext_flush,
  input  logic                   alloc_valid,
  input  logic [REG_W-1:0]       alloc_dest,
  input  logic [1:0]             alloc_type,
  output logic                   alloc_ready,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic [WB_CH-1:0]       wb_valid,
  input  logic [WB_CH*TAG_W-1:0] wb_tag,
  input  logic [WB_CH*XLEN-1:0]  wb_value,
  input  logic [WB_CH-1:0]       wb_mispred,
  input  logic [WB_CH*XLEN-1:0]  wb_target,
  input  logic [TAG_W-1:0]       query_tag,
  output logic                   query_ready,
  output logic [XLEN-1:0]        query_value,
  output logic [CMT_W-1:0]       cmt_valid,
  output logic [CMT_W*REG_W-1:0] cmt_dest,
  output logic [CMT_W*XLEN-1:0]  cmt_value,
  output logic [CMT_W-1:0]       cmt_store,
  output logic                   flush_valid,
  output logic [XLEN-1:0]        flush_pc,
  output logic [TAG_W:0]         count,
  output logic                   empty
);

  localparam int PTR_W = TAG_W + 1;
  localparam int CNT_W = $clog2(CMT_W + 1);

  // Pointer and per-entry state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             done_q [DEPTH];
  logic             done_d [DEPTH];
  logic             mis_q  [DEPTH];
  logic             mis_d  [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [XLEN-1:0]  val_d  [DEPTH];
  logic [XLEN-1:0]  tgt_q  [DEPTH];
  logic [XLEN-1:0]  tgt_d  [DEPTH];
  logic [REG_W-1:0] dest_q [DEPTH];
  logic [REG_W-1:0] dest_d [DEPTH];
  logic [1:0]       type_q [DEPTH];
  logic [1:0]       type_d [DEPTH];

  // Registered retirement / redirect outputs
  logic [CMT_W-1:0]       cmt_valid_q, cmt_valid_d;
  logic [CMT_W*REG_W-1:0] cmt_dest_q, cmt_dest_d;
  logic [CMT_W*XLEN-1:0]  cmt_value_q, cmt_value_d;
  logic [CMT_W-1:0]       cmt_store_q, cmt_store_d;
  logic                   flush_valid_q, flush_valid_d;
  logic [XLEN-1:0]        flush_pc_q, flush_pc_d;

  // Head window and selector results
  logic [PTR_W-1:0]   count_s;
  logic               alloc_ok_s;
  logic [TAG_W-1:0]   win_idx_s [CMT_W];
  logic [CMT_W-1:0]   win_live_s;
  logic [CMT_W-1:0]   win_ready_s;
  logic [CMT_W-1:0]   win_mis_s;
  logic [2*CMT_W-1:0] win_type_s;
  logic [CMT_W-1:0]   sel_mask_s;
  logic [CNT_W-1:0]   sel_adv_s;
  logic [CMT_W-1:0]   sel_flush_slot_s;
  logic               sel_flush_hit_s;
  logic [XLEN-1:0]    flush_tgt_s;
  logic [PTR_W-1:0]   head_adv_s;
  logic [TAG_W-1:0]   wb_idx_s;

  // An index is live when its distance from the head is below the occupancy.
  function automatic logic is_live(input logic [TAG_W-1:0] idx,
                                   input logic [TAG_W-1:0] head_idx,
                                   input logic [PTR_W-1:0] occ);
    logic [TAG_W-1:0] off;
    off = idx - head_idx;
    return ({1'b0, off} < occ);
  endfunction

  assign count_s    = tail_q - head_q;
  assign alloc_ok_s = (count_s < PTR_W'(DEPTH));
  assign head_adv_s = head_q + PTR_W'(sel_adv_s);

  // Gather ready/type/mispred of the CMT_W oldest entries for the selector.
  always_comb begin
    win_live_s  = '0;
    win_ready_s = '0;
    win_mis_s   = '0;
    win_type_s  = '0;
    for (int k = 0; k < CMT_W; k++) begin
      win_idx_s[k]          = head_q[TAG_W-1:0] + TAG_W'(k);
      win_live_s[k]         = (PTR_W'(k) < count_s);
      win_ready_s[k]        = done_q[win_idx_s[k]];
      win_mis_s[k]          = mis_q[win_idx_s[k]];
      win_type_s[2*k +: 2]  = type_q[win_idx_s[k]];
    end
  end

  rob_mc_commit_sel #(
    .CMT_W (CMT_W),
    .CNT_W (CNT_W)
  ) u_commit_sel (
    .win_live    (win_live_s),
    .win_ready   (win_ready_s),
    .win_mispred (win_mis_s),
    .win_type    (win_type_s),
    .cmt_mask    (sel_mask_s),
    .adv_cnt     (sel_adv_s),
    .flush_slot  (sel_flush_slot_s),
    .flush_hit   (sel_flush_hit_s)
  );

  // Pick the redirect target of the branch that closes the commit group.
  always_comb begin
    flush_tgt_s = '0;
    for (int k = 0; k < CMT_W; k++) begin
      if (sel_flush_slot_s[k]) begin
        flush_tgt_s = tgt_q[win_idx_s[k]];
      end else begin
        flush_tgt_s = flush_tgt_s;
      end
    end
  end

  // Next-state: freeze on stall, external flush beats mispredict, otherwise retire, allocate and accept writebacks.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    done_d        = done_q;
    mis_d         = mis_q;
    val_d         = val_q;
    tgt_d         = tgt_q;
    dest_d        = dest_q;
    type_d        = type_q;
    cmt_valid_d   = '0;
    cmt_dest_d    = cmt_dest_q;
    cmt_value_d   = cmt_value_q;
    cmt_store_d   = cmt_store_q;
    flush_valid_d = 1'b0;
    flush_pc_d    = flush_pc_q;
    wb_idx_s      = '0;
    if (!rdy) begin
      head_d = head_q;
    end else if (ext_flush) begin
      head_d      = tail_q;
      cmt_store_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        done_d[i] = 1'b0;
      end
    end else begin
      cmt_store_d = '0;
      for (int k = 0; k < CMT_W; k++) begin
        if (sel_mask_s[k]) begin
          cmt_valid_d[k]                = 1'b1;
          cmt_dest_d[k*REG_W +: REG_W]  = dest_q[win_idx_s[k]];
          cmt_value_d[k*XLEN +: XLEN]   = val_q[win_idx_s[k]];
          cmt_store_d[k]                = rob_is_store(type_q[win_idx_s[k]]);
        end else begin
          cmt_valid_d[k] = 1'b0;
        end
      end
      head_d = head_adv_s;
      if (sel_flush_hit_s) begin
        // Everything younger than the branch is discarded; this cycle's
        // allocation and results are dropped with it.
        tail_d        = head_adv_s;
        flush_valid_d = 1'b1;
        flush_pc_d    = flush_tgt_s;
        for (int i = 0; i < DEPTH; i++) begin
          done_d[i] = 1'b0;
        end
      end else begin
        if (alloc_valid && alloc_ok_s) begin
          done_d[tail_q[TAG_W-1:0]] = 1'b0;
          mis_d[tail_q[TAG_W-1:0]]  = 1'b0;
          dest_d[tail_q[TAG_W-1:0]] = alloc_dest;
          type_d[tail_q[TAG_W-1:0]] = alloc_type;
          tail_d                    = tail_q + PTR_W'(1);
        end else begin
          tail_d = tail_q;
        end
        // Highest channel first so the lowest channel's write lands last.
        for (int ch = WB_CH - 1; ch >= 0; ch--) begin
          wb_idx_s = wb_tag[ch*TAG_W +: TAG_W];
          if (wb_valid[ch] && is_live(wb_idx_s, head_q[TAG_W-1:0], count_s)) begin
            done_d[wb_idx_s] = 1'b1;
            val_d[wb_idx_s]  = wb_value[ch*XLEN +: XLEN];
            mis_d[wb_idx_s]  = wb_mispred[ch];
            tgt_d[wb_idx_s]  = wb_target[ch*XLEN +: XLEN];
          end else begin
            wb_idx_s = wb_idx_s;
          end
        end
      end
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      cmt_valid_q   <= '0;
      cmt_dest_q    <= '0;
      cmt_value_q   <= '0;
      cmt_store_q   <= '0;
      flush_valid_q <= 1'b0;
      flush_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        done_q[i] <= 1'b0;
        mis_q[i]  <= 1'b0;
        val_q[i]  <= '0;
        tgt_q[i]  <= '0;
        dest_q[i] <= '0;
        type_q[i] <= 2'd0;
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      cmt_valid_q   <= cmt_valid_d;
      cmt_dest_q    <= cmt_dest_d;
      cmt_value_q   <= cmt_value_d;
      cmt_store_q   <= cmt_store_d;
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
      for (int i = 0; i < DEPTH; i++) begin
        done_q[i] <= done_d[i];
        mis_q[i]  <= mis_d[i];
        val_q[i]  <= val_d[i];
        tgt_q[i]  <= tgt_d[i];
        dest_q[i] <= dest_d[i];
        type_q[i] <= type_d[i];
      end
    end
  end

  assign alloc_ready = alloc_ok_s;
  assign alloc_tag   = tail_q[TAG_W-1:0];
  assign count       = count_s;
  assign empty       = (count_s == '0);
  assign query_ready = is_live(query_tag, head_q[TAG_W-1:0], count_s) & done_q[query_tag];
  assign query_value = val_q[query_tag];
  assign cmt_valid   = cmt_valid_q;
  assign cmt_dest    = cmt_dest_q;
  assign cmt_value   = cmt_value_q;
  assign cmt_store   = cmt_store_q;
  assign flush_valid = flush_valid_q;
  assign flush_pc    = flush_pc_q;

endmodule

// File: tb/tb_rob_mc.sv
// Scoreboard bench for rob_mc: every allocation pushes the expected retirement
// record; a negedge monitor pops one record per commit pulse and compares it.
`timescale 1ns/1ps
module tb_rob_mc;
  import rob_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        ext_flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_dest = 5'd0;
  logic [1:0]  alloc_type = 2'd0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [2:0]  wb_valid = 3'd0;
  logic [11:0] wb_tag = 12'd0;
  logic [95:0] wb_value = 96'd0;
  logic [2:0]  wb_mispred = 3'd0;
  logic [95:0] wb_target = 96'd0;
  logic [3:0]  query_tag = 4'd0;
  logic        query_ready;
  logic [31:0] query_value;
  logic [1:0]  cmt_valid;
  logic [9:0]  cmt_dest;
  logic [63:0] cmt_value;
  logic [1:0]  cmt_store;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic [4:0]  count;
  logic        empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] value;
    logic        store;
  } exp_t;
  exp_t exp_q[$];

  rob_mc dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ext_flush(ext_flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_type(alloc_type),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_mispred(wb_mispred), .wb_target(wb_target),
    .query_tag(query_tag), .query_ready(query_ready), .query_value(query_value),
    .cmt_valid(cmt_valid), .cmt_dest(cmt_dest), .cmt_value(cmt_value), .cmt_store(cmt_store),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Commit monitor: each pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (cmt_valid[1] === 1'b1 && cmt_valid[0] !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL cmt_slot_order: cmt_valid=%b, slot1 requires slot0", cmt_valid);
      end
      for (int k = 0; k < 2; k++) begin
        if (cmt_valid[k] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmt_unexpected: slot %0d dest=%0d value=%h, no commit expected",
                     k, cmt_dest[k*5 +: 5], cmt_value[k*32 +: 32]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cmt_dest[k*5 +: 5] !== e.dest || cmt_value[k*32 +: 32] !== e.value ||
                cmt_store[k] !== e.store) begin
              errors++;
              $display("FAIL cmt_data: slot %0d got dest=%0d value=%h store=%b, want dest=%0d value=%h store=%b",
                       k, cmt_dest[k*5 +: 5], cmt_value[k*32 +: 32], cmt_store[k],
                       e.dest, e.value, e.store);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = 3'd0; wb_tag = 12'd0; wb_value = 96'd0; wb_mispred = 3'd0; wb_target = 96'd0;
  endtask

  task automatic set_wb(input int ch, input logic [3:0] tag, input logic [31:0] val,
                        input logic mis, input logic [31:0] tgt);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*4 +: 4] = tag;
    wb_value[ch*32 +: 32] = val;
    wb_mispred[ch] = mis;
    wb_target[ch*32 +: 32] = tgt;
  endtask

  // One-cycle allocation; records expectation and returns the observed grant.
  task automatic do_alloc(input logic [4:0] dest, input logic [1:0] typ, input logic [31:0] val,
                          output logic [3:0] tag, output logic rd);
    exp_t e;
    alloc_valid = 1'b1; alloc_dest = dest; alloc_type = typ;
    tag = alloc_tag;
    rd = alloc_ready;
    e.dest = dest; e.value = val; e.store = (typ == ROB_STORE);
    exp_q.push_back(e);
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if ({cmt_valid, cmt_store, flush_valid} !== 5'd0) begin
      errors++; $display("FAIL reset_pulses: valid=%b store=%b flush=%b, want 0", cmt_valid, cmt_store, flush_valid);
    end
    checks++;
    if (cmt_dest !== 10'd0 || cmt_value !== 64'd0 || flush_pc !== 32'd0) begin
      errors++; $display("FAIL reset_data: dest=%h value=%h pc=%h, want 0", cmt_dest, cmt_value, flush_pc);
    end
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
      errors++; $display("FAIL reset_ptr: count=%0d empty=%b ready=%b tag=%0d, want 0 1 1 0", count, empty, alloc_ready, alloc_tag);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [3:0] tg; logic rd;
    for (int i = 0; i < 16; i++) begin
      do_alloc(5'(i + 1), ROB_ALU, 32'h0, tg, rd);
      checks++;
      if (rd !== 1'b1 || tg !== 4'(i)) begin
        errors++; $display("FAIL fill_tag: ready=%b tag=%0d, want 1 %0d", rd, tg, i);
      end
    end
    checks++;
    if (count !== 5'd16 || alloc_ready !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL fill_full: count=%0d ready=%b empty=%b, want 16 0 0", count, alloc_ready, empty);
    end
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 5'd16) begin
      errors++; $display("FAIL fill_overflow: count=%0d, want 16", count);
    end
    ext_flush = 1'b1;
    step();
    ext_flush = 1'b0;
    exp_q.delete();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || cmt_valid !== 2'b00 || flush_valid !== 1'b0) begin
      errors++; $display("FAIL ext_flush: count=%0d empty=%b valid=%b flush=%b, want 0 1 00 0", count, empty, cmt_valid, flush_valid);
    end
  endtask

  task automatic test_out_of_order();
    logic [3:0] tg; logic rd;
    for (int i = 0; i < 4; i++) begin
      do_alloc(5'(8 + i), ROB_ALU, 32'h11 * 32'(i + 1), tg, rd);
      checks++;
      if (tg !== 4'(i)) begin
        errors++; $display("FAIL ooo_tag: tag=%0d, want %0d", tg, i);
      end
    end
    set_wb(0, 4'd1, 32'h22, 1'b0, 32'h0); step(); clear_wb();
    query_tag = 4'd1; #1;
    checks++;
    if (query_ready !== 1'b1 || query_value !== 32'h22) begin
      errors++; $display("FAIL query_hit: ready=%b value=%h, want 1 22", query_ready, query_value);
    end
    query_tag = 4'd0; #1;
    checks++;
    if (query_ready !== 1'b0 || cmt_valid !== 2'b00) begin
      errors++; $display("FAIL query_pending: ready=%b valid=%b, want 0 00", query_ready, cmt_valid);
    end
    set_wb(0, 4'd0, 32'h11, 1'b0, 32'h0); step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b00) begin
      errors++; $display("FAIL ooo_early: valid=%b, want 00", cmt_valid);
    end
    set_wb(0, 4'd3, 32'h44, 1'b0, 32'h0); step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b11) begin
      errors++; $display("FAIL ooo_pair01: valid=%b, want 11", cmt_valid);
    end
    set_wb(0, 4'd2, 32'h33, 1'b0, 32'h0); step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b00) begin
      errors++; $display("FAIL ooo_hold3: valid=%b, want 00", cmt_valid);
    end
    step();
    checks++;
    if (cmt_valid !== 2'b11) begin
      errors++; $display("FAIL ooo_pair23: valid=%b, want 11", cmt_valid);
    end
    step();
    query_tag = 4'd3; #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || query_ready !== 1'b0) begin
      errors++; $display("FAIL ooo_drain: count=%0d empty=%b qready=%b, want 0 1 0", count, empty, query_ready);
    end
  endtask

  task automatic test_same_tag();
    logic [3:0] tg; logic rd;
    do_alloc(5'd12, ROB_ALU, 32'h55, tg, rd);
    do_alloc(5'd13, ROB_ALU, 32'hAA, tg, rd);
    checks++;
    if (tg !== 4'd5) begin
      errors++; $display("FAIL same_tag_alloc: tag=%0d, want 5", tg);
    end
    set_wb(0, 4'd5, 32'hAA, 1'b0, 32'h0);
    set_wb(1, 4'd4, 32'h55, 1'b0, 32'h0);
    set_wb(2, 4'd5, 32'hBB, 1'b0, 32'h0);
    step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b00) begin
      errors++; $display("FAIL wb_bypass: valid=%b, want 00", cmt_valid);
    end
    step();
    checks++;
    if (cmt_valid !== 2'b11 || cmt_value[63:32] !== 32'hAA) begin
      errors++; $display("FAIL same_tag_win: valid=%b value=%h, want 11 000000aa", cmt_valid, cmt_value[63:32]);
    end
    step();
  endtask

  task automatic test_mispred();
    logic [3:0] tg; logic rd;
    rst = 1'b0; step(); rst = 1'b1; step();
    exp_q.delete();
    do_alloc(5'd1, ROB_ALU, 32'h100, tg, rd);
    do_alloc(5'd2, ROB_ALU, 32'h101, tg, rd);
    do_alloc(5'd3, ROB_BRANCH, 32'h0C, tg, rd);
    checks++;
    if (tg !== 4'd2) begin
      errors++; $display("FAIL mp_branch_tag: tag=%0d, want 2", tg);
    end
    for (int i = 0; i < 4; i++) begin
      do_alloc(5'(4 + i), ROB_ALU, 32'h200 + 32'(i), tg, rd);
    end
    set_wb(0, 4'd0, 32'h100, 1'b0, 32'h0);
    set_wb(1, 4'd1, 32'h101, 1'b0, 32'h0);
    set_wb(2, 4'd2, 32'h0C, 1'b1, 32'h1000);
    step(); clear_wb();
    set_wb(0, 4'd3, 32'h200, 1'b0, 32'h0);
    set_wb(1, 4'd4, 32'h201, 1'b0, 32'h0);
    set_wb(2, 4'd5, 32'h202, 1'b0, 32'h0);
    step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b11 || flush_valid !== 1'b0) begin
      errors++; $display("FAIL mp_older: valid=%b flush=%b, want 11 0", cmt_valid, flush_valid);
    end
    set_wb(0, 4'd6, 32'h203, 1'b0, 32'h0);
    step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b01 || flush_valid !== 1'b1 || flush_pc !== 32'h1000 || count !== 5'd0) begin
      errors++; $display("FAIL mp_flush: valid=%b flush=%b pc=%h count=%0d, want 01 1 00001000 0",
                         cmt_valid, flush_valid, flush_pc, count);
    end
    @(negedge clk); #1;
    exp_q.delete();
    query_tag = 4'd3; #1;
    checks++;
    if (query_ready !== 1'b0) begin
      errors++; $display("FAIL mp_query: ready=%b, want 0", query_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cmt_valid !== 2'b00 || flush_valid !== 1'b0 || count !== 5'd0) begin
        errors++; $display("FAIL mp_quiet: valid=%b flush=%b count=%0d, want 00 0 0", cmt_valid, flush_valid, count);
      end
    end
  endtask

  task automatic test_stores_wrap();
    logic [3:0] tg; logic rd;
    do_alloc(5'd0, ROB_STORE, 32'h5000, tg, rd);
    do_alloc(5'd0, ROB_STORE, 32'h5001, tg, rd);
    checks++;
    if (tg !== 4'd4) begin
      errors++; $display("FAIL st_tag: tag=%0d, want 4", tg);
    end
    set_wb(0, 4'd3, 32'h5000, 1'b0, 32'h0);
    set_wb(1, 4'd4, 32'h5001, 1'b0, 32'h0);
    step(); clear_wb();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (cmt_valid !== 2'b01 || cmt_store !== 2'b01) begin
        errors++; $display("FAIL st_single: cycle %0d valid=%b store=%b, want 01 01", i, cmt_valid, cmt_store);
      end
    end
    for (int i = 0; i < 9; i++) begin
      do_alloc(5'd1, ROB_ALU, 32'h0, tg, rd);
    end
    ext_flush = 1'b1; step(); ext_flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      do_alloc(5'(20 + i), ROB_ALU, 32'h700 + 32'(i), tg, rd);
      checks++;
      if (tg !== 4'(14 + i)) begin
        errors++; $display("FAIL wrap_tag: tag=%0d, want %0d", tg, (14 + i) % 16);
      end
    end
    set_wb(0, 4'd14, 32'h700, 1'b0, 32'h0);
    set_wb(1, 4'd15, 32'h701, 1'b0, 32'h0);
    set_wb(2, 4'd0,  32'h702, 1'b0, 32'h0);
    step(); clear_wb();
    set_wb(0, 4'd1, 32'h703, 1'b0, 32'h0);
    step(); clear_wb();
    checks++;
    if (cmt_valid !== 2'b11) begin
      errors++; $display("FAIL wrap_first: valid=%b, want 11", cmt_valid);
    end
    step();
    checks++;
    if (cmt_valid !== 2'b11 || count !== 5'd0) begin
      errors++; $display("FAIL wrap_second: valid=%b count=%0d, want 11 0", cmt_valid, count);
    end
  endtask

  task automatic test_rdy_stall();
    logic [3:0] tg; logic rd;
    do_alloc(5'd7, ROB_ALU, 32'h900, tg, rd);
    checks++;
    if (tg !== 4'd2) begin
      errors++; $display("FAIL stall_tag: tag=%0d, want 2", tg);
    end
    set_wb(0, 4'd2, 32'h900, 1'b0, 32'h0); step(); clear_wb();
    rdy = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 5'd9; alloc_type = ROB_ALU;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cmt_valid !== 2'b00 || count !== 5'd1) begin
        errors++; $display("FAIL stall_hold: cycle %0d valid=%b count=%0d, want 00 1", i, cmt_valid, count);
      end
    end
    alloc_valid = 1'b0;
    rdy = 1'b1;
    step();
    checks++;
    if (cmt_valid !== 2'b01 || count !== 5'd0) begin
      errors++; $display("FAIL stall_release: valid=%b count=%0d, want 01 0", cmt_valid, count);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] tg; logic rd;
    for (int i = 0; i < 7; i++) begin
      do_alloc(5'(10 + i), ROB_ALU, 32'hC00 + 32'(i), tg, rd);
    end
    set_wb(0, 4'd3, 32'hC00, 1'b0, 32'h0);
    set_wb(1, 4'd4, 32'hC01, 1'b0, 32'h0);
    step(); clear_wb();
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL rm_live: count=%0d, want 7", count);
    end
    rst = 1'b0; #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || cmt_valid !== 2'b00 || flush_valid !== 1'b0 ||
        cmt_dest !== 10'd0 || cmt_value !== 64'd0 || flush_pc !== 32'd0 || cmt_store !== 2'b00) begin
      errors++; $display("FAIL rm_clear: count=%0d empty=%b valid=%b dest=%h value=%h pc=%h, want all cleared",
                         count, empty, cmt_valid, cmt_dest, cmt_value, flush_pc);
    end
    exp_q.delete();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (cmt_valid !== 2'b00 || count !== 5'd0) begin
        errors++; $display("FAIL rm_quiet: valid=%b count=%0d, want 00 0", cmt_valid, count);
      end
    end
  endtask

  initial begin
    clear_wb();
    test_reset();
    test_fill();
    test_out_of_order();
    test_same_tag();
    test_mispred();
    test_stores_wrap();
    test_rdy_stall();
    test_reset_mid();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected commits never seen, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_mc.md
Name: rob_mc

Overview:
- Parametrised reorder buffer, successor to the single-commit ROB.
- Sits between decode/issue and the register file / load-store buffer.
- Allocates one entry per cycle, accepts WB_CH result channels per cycle, and retires up to CMT_W entries in order per cycle.
- Handles branch mispredict flush from the head, an external flush, and a combinational operand-forwarding query port.

Parameters:
DEPTH, 16, entry count; power of 2, >= 4
TAG_W, $clog2(DEPTH), entry tag width
REG_W, 5, architectural register index width
XLEN, 32, data width
WB_CH, 3, number of writeback channels
CMT_W, 2, maximum commits per cycle

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global stall; low freezes all state
ext_flush  in  1  external clear of all entries
alloc_valid  in  1  allocation request
alloc_dest  in  REG_W  destination register (0 = no register write)
alloc_type  in  2  ROB_ALU / ROB_LOAD / ROB_STORE / ROB_BRANCH
alloc_ready  out  1  entry free (count < DEPTH)
alloc_tag  out  TAG_W  tag granted to the current request
wb_valid  in  WB_CH  per-channel result valid
wb_tag  in  WB_CH*TAG_W  per-channel entry tag
wb_value  in  WB_CH*XLEN  result (branch: link value)
wb_mispred  in  WB_CH  branch resolved mispredicted
wb_target  in  WB_CH*XLEN  redirect PC
query_tag  in  TAG_W  forwarding lookup
query_ready  out  1  entry live and ready (combinational)
query_value  out  XLEN  entry value (combinational)
cmt_valid  out  CMT_W  per-slot commit pulse; slot 0 is oldest
cmt_dest  out  CMT_W*REG_W  committed destination
cmt_value  out  CMT_W*XLEN  committed value
cmt_store  out  CMT_W  committed entry is a store
flush_valid  out  1  mispredict redirect pulse
flush_pc  out  XLEN  redirect target
count  out  TAG_W+1  occupied entries
empty  out  1  count == 0

Behaviour:
Reset (rst low, asynchronous):
- head = tail = 0; all ready/mispred bits = 0.
- cmt_valid, cmt_store, flush_valid = 0.
- cmt_dest, cmt_value, flush_pc = 0.
Pointers and occupancy:
- head and tail are TAG_W+1 bits with a wrap bit.
- count = tail - head (modulo 2^(TAG_W+1)); full when count == DEPTH.
- Entry index = pointer[TAG_W-1:0].
rdy low:
- No state changes.
- cmt_valid and flush_valid are driven 0 for that cycle; the other outputs hold.
Allocation:
- Accepted when alloc_valid & alloc_ready & rdy.
- alloc_tag = tail index; entry written with dest/type, ready = 0, mispred = 0; tail++.
- alloc_ready uses the current count only; no bypass of slots freed by a same-cycle commit.
Writeback:
- Channel i with wb_valid[i] sets ready, value, mispred and target of entry wb_tag[i].
- Writebacks to non-live entries are ignored.
- If two channels target the same tag in one cycle, the lowest channel index wins.
- No same-cycle bypass into commit or query: a result written at edge E is earliest committed in the outputs after edge E+1.
Commit:
- Scan slots k = 0..CMT_W-1 starting at head; slot k commits iff all older slots commit and entry head+k is live and ready.
- At most one store per cycle: a store in slot k > 0 waits if an older slot in the same group is a store.
- A mispredicted branch commits (cmt_valid, cmt_dest/link value) and ends the group. Same edge: flush_valid = 1, flush_pc = its target; head and tail both set to the branch's successor pointer; all ready bits cleared.
- Outputs are registered and pulse for one cycle; head advances by the number of slots committed.
Flush rules:
- Allocation and writeback in a flush cycle are discarded.
- ext_flush: same clearing (head = tail, ready bits = 0) with no commits and flush_valid = 0. It has priority over an internal mispredict in the same cycle.
Wrap-around:
- Pointer wrap is transparent; a tag is reused only after its entry retires.
Query port:
- query_ready = live(query_tag) & ready[query_tag]; query_value = value[query_tag].
- Purely combinational; no bypass of same-cycle writebacks.

Decomposition:
- Shared def package: ROB_ALU = 0, ROB_LOAD = 1, ROB_STORE = 2, ROB_BRANCH = 3; default widths for DEPTH, REG_W, XLEN.
- One sub-module, rob_mc_commit_sel: combinational slot-selection logic. Inputs are the head-window ready/type/mispred bits. Outputs are the per-slot commit mask, advance count and flush-slot indicator.

Test Plan:
- Reset, then allocate 16 entries with rdy = 1 -> alloc_ready falls after the 16th, count = 16; a 17th request gets no tag.
- Allocate tags 0..3; writeback 1, 0, 3, 2 in consecutive cycles, values 0x11..0x44 -> commits in tag order only: {0,1} in one cycle, then {2,3}; cmt_value matches the tags.
- Same-cycle writeback of tag 5 on ch0 (0xAA) and ch2 (0xBB) -> commits 0xAA.
- Tag 2 is a branch with wb_mispred = 1, target 0x1000; tags 3–6 live -> branch commits, flush_valid = 1, flush_pc = 0x1000; next cycle count = 0 and tags 3–6 never commit.
- Two adjacent ready stores at head -> one cmt_store per cycle over two cycles. Then fill to wrap (head = 14, allocate 4) -> tags 14, 15, 0, 1; in-order commit continues across the wrap.
- Drop rst mid-stream with 7 live entries -> immediate count = 0, all outputs 0, no commit pulse after release. Also, rdy low for 3 cycles with a ready head -> no commit until rdy returns.
